demux_lane_collector: RTL
=========================

# demux_lane_collector

Downstream stage of the 1:4 demultiplexer, `demux_1_4`. It samples the four demux outputs `y0`..`y3` together with the select lines that drove them. It deserialises each lane's bit stream into WIDTH-bit words and presents each completed word on a per-lane valid/ack handshake, with sticky overflow detection.

## Interface
Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- sel0  in  1  demux select MSB, same signal that drives `demux_1_4`.
- sel1  in  1  demux select LSB.
- y0, y1, y2, y3  in  1 each  demux outputs.
- bit_vld  in  1  qualifies the current select/output set as one data bit.
- flush  in  1  discards all partial words. Does not affect completed words.
- lane_data0..lane_data3  out  WIDTH each  assembled word per lane.
- lane_vld  out  4  bit n = lane n holds an unacknowledged word.
- lane_ack  in  4  bit n consumes lane n's word when `lane_vld[n]` = 1.
- overflow  out  4  sticky; bit n = a word for lane n was dropped.

## Operation
- Active lane index is {sel0, sel1}: 0→y0, 1→y1, 2→y2, 3→y3.
- Bit sampling:
  - Each cycle with `bit_vld` = 1, the active lane's y bit is shifted into that lane's shift register, MSB first.
  - The other three lanes are untouched, and their y inputs are ignored.
- Each lane keeps a bit counter of width clog2(WIDTH) running 0..WIDTH-1.
- Word completion: on the WIDTH-th bit, the counter wraps to 0. Then:
  - if the lane's output slot is empty, or is being acked in the same cycle, the word is loaded into `lane_dataN` and `lane_vldN` = 1;
  - otherwise the word is dropped, `overflow[n]` is set, and the held word is unchanged.
- Handshake:
  - `lane_vld[n]` stays high, and `lane_data[n]` stays stable, until a cycle with `lane_ack[n]` = 1.
  - `lane_vld[n]` clears after that cycle unless a new word loads in the same cycle.
  - `lane_ack` is ignored when `lane_vld` = 0.
- flush:
  - clears all bit counters and shift registers at the next edge.
  - If `flush` and `bit_vld` are both 1, flush wins and the bit is discarded.
  - `lane_vld`, `lane_data` and `overflow` are unaffected.
- overflow clears only on `rst`.

## Timing
- Reset values:
  - `lane_data0`..`lane_data3` = 0;
  - `lane_vld` = 4'b0000;
  - `overflow` = 4'b0000;
  - all counters and shift registers = 0.
- `rst` mid-word discards all partial and pending words with no overflow indication. `rst` has priority over every other input.
- Latency: the WIDTH-th bit sampled at edge k gives `lane_vld` high and valid data immediately after edge k. That is registered, 1-cycle latency from the final bit.
- Full throughput: a lane can complete one word every WIDTH `bit_vld` cycles with no bubbles, provided it is acked in or before the completing cycle.
- All four lanes are independent. Interleaved selects build words in parallel, each lane keeping its own count.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `demux_pkg`:
  - `LANES` = 4;
  - `lane_idx_t` (2-bit);
  - the lane-index function from {sel0, sel1}.
- Sub-module `lane_deser`, instantiated 4 times, one per lane. Its inputs are:
  - `clk`, `rst`, `flush`;
  - `shift_en` = `bit_vld` AND (active lane == n);
  - `din` = y of lane n;
  - `ack`.
  Its outputs are `data`, `vld` and `ovf`.
- The top level holds only the lane decode and the instances.

## Test plan
- Reset then idle: `rst` for 2 cycles → all outputs 0. `lane_ack` pulses → no change.
- Lane 2 byte, WIDTH = 8:
  - Stimulus: {sel0, sel1} = 2'b10, `bit_vld` for 8 cycles, y2 = 1,0,1,0,0,1,0,1.
  - Response: `lane_data2` = 8'hA5 and `lane_vld` = 4'b0100 one edge after the 8th bit.
  - `lane_ack[2]` for 1 cycle → `lane_vld` = 0.
- Interleave:
  - Stimulus: alternate lanes 0 and 3 each cycle for 16 `bit_vld` cycles. Lane 0 gets 8'hFF, lane 3 gets 8'h00.
  - Response: both valid after the 16th bit. `lane_data0` = FF, `lane_data3` = 00.
- Overflow:
  - Stimulus: two back-to-back 8'h3C words into lane 1 with no ack.
  - Response: `lane_data1` = 3C held and `overflow` = 4'b0010.
  - Same sequence with `lane_ack[1]` on the 16th-bit cycle → second word loads, no overflow.
- Flush mid-word: 5 bits into lane 0, then `flush`, then 8 bits of 8'h81 → `lane_data0` = 81. `flush` together with `bit_vld` drops that bit.
- Reset mid-operation: `rst` after 4 bits of lane 3 with `lane_vld[1]` pending → all cleared. The next 8 bits of lane 3 form a clean word.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the demux_1_4 downstream collector.
//   LANES      : number of demux outputs / deserialiser lanes
//   lane_idx_t : 2-bit lane index
//   lane_idx() : maps the demux select pair {sel0, sel1} to the active lane
package demux_pkg;

  localparam int unsigned LANES = 4;

  typedef logic [1:0] lane_idx_t;

  // sel0 is the select MSB, so {sel0, sel1} is directly the lane number.
  function automatic lane_idx_t lane_idx(input logic sel0, input logic sel1);
    return {sel0, sel1};
  endfunction

endpackage

// File: rtl/lane_deser.sv
// Single-lane serial-to-parallel word builder with a valid/ack output slot.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : drop the partial word (counter and shift register)
//   shift_en  : shift din in this cycle (MSB first)
//   din       : serial data bit
//   ack       : consume the held word when vld is high
//   data      : last completed word
//   vld       : data holds an unacknowledged word
//   ovf       : sticky, a completed word was dropped because the slot was full
module lane_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             shift_en,
  input  logic             din,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             ovf
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] word;
  logic             wrap;
  logic             slot_free;

  assign word      = {sr_q[WIDTH-2:0], din};
  // flush beats a simultaneous bit, so it can never complete a word
  assign wrap      = shift_en && !flush && (cnt_q == CntLast);
  // An ack in the completing cycle frees the slot for the new word.
  assign slot_free = !vld || ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
      data  <= '0;
      vld   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (flush) begin
        cnt_q <= '0;
        sr_q  <= '0;
      end else if (shift_en) begin
        sr_q  <= word;
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      end

      if (wrap && slot_free) begin
        data <= word;
        vld  <= 1'b1;
      end else begin
        if (wrap) begin
          ovf <= 1'b1;
        end
        if (ack) begin
          vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/demux_lane_collector.sv
// Collects the four outputs of demux_1_4 into per-lane WIDTH-bit words.
//   clk, rst            : clock, synchronous active-high reset
//   sel0, sel1          : demux select lines (MSB, LSB) picking the active lane
//   y0..y3              : demux outputs; only the active lane's bit is used
//   bit_vld             : current select/output set is one data bit
//   flush               : discard all partial words
//   lane_data0..3       : assembled word per lane
//   lane_vld[3:0]       : lane holds an unacknowledged word
//   lane_ack[3:0]       : consume lane's word
//   overflow[3:0]       : sticky, a word for the lane was dropped
module demux_lane_collector
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel0,
  input  logic             sel1,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             bit_vld,
  input  logic             flush,
  output logic [WIDTH-1:0] lane_data0,
  output logic [WIDTH-1:0] lane_data1,
  output logic [WIDTH-1:0] lane_data2,
  output logic [WIDTH-1:0] lane_data3,
  output logic [3:0]       lane_vld,
  input  logic [3:0]       lane_ack,
  output logic [3:0]       overflow
);

  lane_idx_t        active;
  logic [LANES-1:0] y_vec;
  logic [LANES-1:0] shift_en;
  logic [WIDTH-1:0] data_arr [LANES];

  assign active = lane_idx(sel0, sel1);
  assign y_vec  = {y3, y2, y1, y0};

  always_comb begin
    shift_en = '0;
    for (int n = 0; n < LANES; n++) begin
      shift_en[n] = bit_vld && (active == lane_idx_t'(n));
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    lane_deser #(
      .WIDTH(WIDTH)
    ) u_lane_deser (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .shift_en(shift_en[n]),
      .din     (y_vec[n]),
      .ack     (lane_ack[n]),
      .data    (data_arr[n]),
      .vld     (lane_vld[n]),
      .ovf     (overflow[n])
    );
  end

  assign lane_data0 = data_arr[0];
  assign lane_data1 = data_arr[1];
  assign lane_data2 = data_arr[2];
  assign lane_data3 = data_arr[3];

endmodule
